// File: rtl/hazard_scoreboard_if.sv
// Signal bundle between the pipeline stage registers and the hazard scoreboard:
// decoded register/timing fields in, stall and forwarding selects out.
interface hazard_scoreboard_if #(
  parameter int RA_W  = 5,
  parameter int T_W   = 2,
  parameter int CNT_W = 16
);
  // ID stage
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic [T_W-1:0]   id_tuse_rs;
  logic [T_W-1:0]   id_tuse_rt;
  logic             id_md_use;
  // EX stage
  logic [RA_W-1:0]  ex_rd;
  logic [T_W-1:0]   ex_tnew;
  logic [RA_W-1:0]  ex_rs;
  logic [RA_W-1:0]  ex_rt;
  logic             ex_md_start;
  logic             ex_md_div;
  // MEM / WB stages
  logic [RA_W-1:0]  mem_rd;
  logic [T_W-1:0]   mem_tnew;
  logic [RA_W-1:0]  mem_rt;
  logic [RA_W-1:0]  wb_rd;
  logic             stat_clr;
  // Results
  logic             stall;
  logic             fwd_rs_id;
  logic             fwd_rt_id;
  logic [1:0]       fwd_rs_ex;
  logic [1:0]       fwd_rt_ex;
  logic             fwd_rt_mem;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_md_use,
    output ex_rd, ex_tnew, ex_rs, ex_rt, ex_md_start, ex_md_div,
    output mem_rd, mem_tnew, mem_rt, wb_rd, stat_clr,
    input  stall, fwd_rs_id, fwd_rt_id, fwd_rs_ex, fwd_rt_ex, fwd_rt_mem,
    input  md_busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_md_use,
    input  ex_rd, ex_tnew, ex_rs, ex_rt, ex_md_start, ex_md_div,
    input  mem_rd, mem_tnew, mem_rt, wb_rd, stat_clr,
    output stall, fwd_rs_id, fwd_rt_id, fwd_rs_ex, fwd_rt_ex, fwd_rt_mem,
    output md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Five-stage pipeline hazard scoreboard: T_use/T_new data stalls, forwarding selects,
// multi-cycle MDU busy tracking and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int RA_W        = 5,
  parameter int T_W         = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  hazard_scoreboard_if.slave hz
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  localparam logic [MD_W-1:0] MULT_LOAD = MD_W'(MULT_CYCLES);
  localparam logic [MD_W-1:0] DIV_LOAD  = MD_W'(DIV_CYCLES);

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  logic [T_W-1:0]   ex_res;
  logic [T_W-1:0]   mem_res;
  logic             mem_ready;
  logic             data_stall;
  logic             md_stall;
  logic             stall;
  fwd_sel_e         sel_rs_ex;
  fwd_sel_e         sel_rt_ex;

  logic [MD_W-1:0]  md_cnt_q,    md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_match(input logic [RA_W-1:0] src,
                                     input logic [RA_W-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

  function automatic fwd_sel_e ex_fwd_sel(input logic [RA_W-1:0] src,
                                          input logic [RA_W-1:0] mem_rd,
                                          input logic [RA_W-1:0] wb_rd,
                                          input logic            mem_rdy);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (mem_rdy && reg_match(src, mem_rd)) begin
      sel = FWD_MEM;
    end else if (reg_match(src, wb_rd)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Residual cycles until each producer's result exists; T_new was decoded in ID.
  always_comb begin
    ex_res  = (int'(hz.ex_tnew)  > 1) ? hz.ex_tnew  - T_W'(1) : '0;
    mem_res = (int'(hz.mem_tnew) > 2) ? hz.mem_tnew - T_W'(2) : '0;
  end

  assign mem_ready = (mem_res == '0);

  always_comb begin
    data_stall = ((ex_res  > hz.id_tuse_rs) && reg_match(hz.id_rs, hz.ex_rd))
              || ((ex_res  > hz.id_tuse_rt) && reg_match(hz.id_rt, hz.ex_rd))
              || ((mem_res > hz.id_tuse_rs) && reg_match(hz.id_rs, hz.mem_rd))
              || ((mem_res > hz.id_tuse_rt) && reg_match(hz.id_rt, hz.mem_rd));
    // A start in EX this cycle blocks ID even though the counter is still zero.
    md_stall   = hz.id_md_use && ((md_cnt_q != '0) || hz.ex_md_start);
    stall      = data_stall || md_stall;
  end

  assign sel_rs_ex = ex_fwd_sel(hz.ex_rs, hz.mem_rd, hz.wb_rd, mem_ready);
  assign sel_rt_ex = ex_fwd_sel(hz.ex_rt, hz.mem_rd, hz.wb_rd, mem_ready);

  assign hz.stall      = stall;
  assign hz.fwd_rs_id  = mem_ready && reg_match(hz.id_rs, hz.mem_rd);
  assign hz.fwd_rt_id  = mem_ready && reg_match(hz.id_rt, hz.mem_rd);
  assign hz.fwd_rs_ex  = sel_rs_ex;
  assign hz.fwd_rt_ex  = sel_rt_ex;
  assign hz.fwd_rt_mem = reg_match(hz.mem_rt, hz.wb_rd);
  assign hz.md_busy    = (md_cnt_q != '0);
  assign hz.stall_cnt  = stall_cnt_q;

  // A start while already busy is ignored: the running count is never reloaded.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    md_cnt_d = md_cnt_q;
    if (hz.ex_md_start && (md_cnt_q == '0)) begin
      md_cnt_d = hz.ex_md_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_W'(1);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hz.stat_clr) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: reset is asynchronous so the MDU tracker clears mid-operation without a clock.
    if (!reset_n) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops sample together.
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: expected outputs are queued as each cycle is
// driven and compared when sampled at the falling edge; a CNT_W=4 copy covers saturation.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic [4:0] id_rs, id_rt;
    logic [1:0] tu_rs, tu_rt;
    logic       md_use;
    logic [4:0] ex_rd;
    logic [1:0] ex_tnew;
    logic [4:0] ex_rs, ex_rt;
    logic       md_start, md_div;
    logic [4:0] mem_rd;
    logic [1:0] mem_tnew;
    logic [4:0] mem_rt, wb_rd;
    logic       clr;
    logic       x_stall, x_rs_id, x_rt_id;
    logic [1:0] x_rs_ex, x_rt_ex;
    logic       x_rt_mem, x_busy;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic        fwd_rs_id;
    logic        fwd_rt_id;
    logic [1:0]  fwd_rs_ex;
    logic [1:0]  fwd_rt_ex;
    logic        fwd_rt_mem;
    logic        md_busy;
    logic [15:0] stall_cnt;
  } out_t;

  typedef struct {
    out_t  v;
    string tag;
  } sb_t;

  logic        clk;
  logic        reset_n;
  int          n_tests;
  int          n_fail;
  logic [15:0] model_cnt;
  sb_t         exp_q[$];

  hazard_scoreboard_if #(.CNT_W(16)) bus  ();
  hazard_scoreboard_if #(.CNT_W(4))  bus4 ();

  hazard_scoreboard #(.CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (bus.slave)
  );

  hazard_scoreboard #(.CNT_W(4)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic out_t observe();
    return {bus.stall, bus.fwd_rs_id, bus.fwd_rt_id, bus.fwd_rs_ex, bus.fwd_rt_ex,
            bus.fwd_rt_mem, bus.md_busy, bus.stall_cnt};
  endfunction

  task automatic apply(input stim_t s);
    bus.id_rs       = s.id_rs;
    bus.id_rt       = s.id_rt;
    bus.id_tuse_rs  = s.tu_rs;
    bus.id_tuse_rt  = s.tu_rt;
    bus.id_md_use   = s.md_use;
    bus.ex_rd       = s.ex_rd;
    bus.ex_tnew     = s.ex_tnew;
    bus.ex_rs       = s.ex_rs;
    bus.ex_rt       = s.ex_rt;
    bus.ex_md_start = s.md_start;
    bus.ex_md_div   = s.md_div;
    bus.mem_rd      = s.mem_rd;
    bus.mem_tnew    = s.mem_tnew;
    bus.mem_rt      = s.mem_rt;
    bus.wb_rd       = s.wb_rd;
    bus.stat_clr    = s.clr;
  endtask

  // Drive one cycle of stimulus and queue the outputs it should produce.
  task automatic drive(input stim_t s, input string tag);
    sb_t e;
    apply(s);
    e.tag = tag;
    e.v   = {s.x_stall, s.x_rs_id, s.x_rt_id, s.x_rs_ex, s.x_rt_ex,
             s.x_rt_mem, s.x_busy, model_cnt};
    exp_q.push_back(e);
  endtask

  task automatic bus4_set(input logic stall_on, input logic clr);
    bus4.id_rs       = stall_on ? 5'd1 : 5'd0;
    bus4.id_rt       = 5'd0;
    bus4.id_tuse_rs  = 2'd0;
    bus4.id_tuse_rt  = 2'd0;
    bus4.id_md_use   = 1'b0;
    bus4.ex_rd       = stall_on ? 5'd1 : 5'd0;
    bus4.ex_tnew     = stall_on ? 2'd3 : 2'd0;
    bus4.ex_rs       = 5'd0;
    bus4.ex_rt       = 5'd0;
    bus4.ex_md_start = 1'b0;
    bus4.ex_md_div   = 1'b0;
    bus4.mem_rd      = 5'd0;
    bus4.mem_tnew    = 2'd0;
    bus4.mem_rt      = 5'd0;
    bus4.wb_rd       = 5'd0;
    bus4.stat_clr    = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t s;
    sb_t   e;
    reset_n   = 1'b0;
    model_cnt = '0;
    s = '0;
    drive(s, "reset_state");
    #3;
    e = exp_q.pop_front();
    n_tests++;
    if (observe() !== e.v) begin
      n_fail++;
      $display("FAIL %s: observed=%h expected=%h", e.tag, observe(), e.v);
    end
    // A divide start while reset is held must not load the busy counter.
    s = '0;
    s.md_start = 1'b1;
    s.md_div   = 1'b1;
    drive(s, "reset_ignores_start");
    repeat (2) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if (observe() !== e.v) begin
      n_fail++;
      $display("FAIL %s: observed=%h expected=%h", e.tag, observe(), e.v);
    end
    apply('0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    stim_t t[6];
    string n[6];
    sb_t   e;
    foreach (t[i]) t[i] = '0;
    t[0].id_rs = 5'd2; t[0].tu_rs = 2'd1; t[0].ex_rd = 5'd2; t[0].ex_tnew = 2'd3;
    t[0].x_stall = 1'b1;                                        n[0] = "lu_lw_in_ex";
    t[1].id_rs = 5'd2; t[1].tu_rs = 2'd0; t[1].mem_rd = 5'd2; t[1].mem_tnew = 2'd3;
    t[1].x_stall = 1'b1;                                        n[1] = "lu_lw_in_mem_tuse0";
    t[2].id_rs = 5'd2; t[2].tu_rs = 2'd1; t[2].mem_rd = 5'd2; t[2].mem_tnew = 2'd3;
    t[2].x_stall = 1'b0;                                        n[2] = "lu_lw_in_mem_tuse1";
    t[3].ex_rs = 5'd2; t[3].wb_rd = 5'd2; t[3].x_rs_ex = 2'd2;  n[3] = "lu_lw_in_wb_fwd";
    t[4].id_rt = 5'd9; t[4].ex_rd = 5'd9; t[4].ex_tnew = 2'd1;  n[4] = "ex_tnew1_no_stall";
    t[5].id_rt = 5'd9; t[5].tu_rt = 2'd1; t[5].ex_rd = 5'd9; t[5].ex_tnew = 2'd3;
    t[5].x_stall = 1'b1;                                        n[5] = "lu_rt_in_ex";
    foreach (t[i]) begin
      drive(t[i], n[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (observe() !== e.v) begin
        n_fail++;
        $display("FAIL %s: observed=%h expected=%h", e.tag, observe(), e.v);
      end
      if (t[i].clr) model_cnt = '0;
      else if (t[i].x_stall) model_cnt++;
      tick();
    end
  endtask

  task automatic test_forwarding();
    stim_t t[6];
    string n[6];
    sb_t   e;
    foreach (t[i]) t[i] = '0;
    t[0].ex_rs = 5'd5; t[0].mem_rd = 5'd5; t[0].mem_tnew = 2'd1; t[0].wb_rd = 5'd5;
    t[0].x_rs_ex = 2'd1;                                        n[0] = "fwd_mem_wins";
    t[1].ex_rs = 5'd5; t[1].ex_rt = 5'd5; t[1].mem_rd = 5'd5; t[1].mem_tnew = 2'd3;
    t[1].wb_rd = 5'd5; t[1].x_rs_ex = 2'd2; t[1].x_rt_ex = 2'd2;
    t[1].x_stall = 1'b0;                                        n[1] = "fwd_wb_mem_pending";
    t[2].id_rs = 5'd5; t[2].id_rt = 5'd5; t[2].mem_rd = 5'd5; t[2].mem_tnew = 2'd2;
    t[2].mem_rt = 5'd7; t[2].wb_rd = 5'd7;
    t[2].x_rs_id = 1'b1; t[2].x_rt_id = 1'b1; t[2].x_rt_mem = 1'b1;
    n[2] = "fwd_id_and_store";
    t[3].ex_tnew = 2'd3; t[3].mem_tnew = 2'd1;                  n[3] = "reg0_never_matches";
    t[4].ex_rt = 5'd6; t[4].mem_rd = 5'd6; t[4].mem_tnew = 2'd3; t[4].wb_rd = 5'd3;
    n[4] = "fwd_mem_not_ready";
    t[5].id_rt = 5'd4; t[5].mem_rd = 5'd4; t[5].mem_tnew = 2'd3;
    t[5].x_stall = 1'b1;                                        n[5] = "mem_stall_rt";
    foreach (t[i]) begin
      drive(t[i], n[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (observe() !== e.v) begin
        n_fail++;
        $display("FAIL %s: observed=%h expected=%h", e.tag, observe(), e.v);
      end
      if (t[i].clr) model_cnt = '0;
      else if (t[i].x_stall) model_cnt++;
      tick();
    end
  endtask

  // Divide started at k=0 with an MDU instruction waiting in ID throughout.
  task automatic test_div_busy();
    stim_t s;
    sb_t   e;
    for (int k = 0; k <= 12; k++) begin
      s = '0;
      s.md_use   = (k <= 11);
      s.md_start = (k == 0);
      s.md_div   = 1'b1;
      s.x_busy   = (k >= 1) && (k <= 10);
      s.x_stall  = (k <= 10);
      drive(s, $sformatf("div_busy_k%0d", k));
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (observe() !== e.v) begin
        n_fail++;
        $display("FAIL %s: observed=%h expected=%h", e.tag, observe(), e.v);
      end
      if (s.clr) model_cnt = '0;
      else if (s.x_stall) model_cnt++;
      tick();
    end
  endtask

  // Multiply at k=0, ignored divide start at k=2, fresh multiply at k=6 once idle.
  task automatic test_mult_restart();
    stim_t s;
    sb_t   e;
    for (int k = 0; k <= 12; k++) begin
      s = '0;
      s.md_start = (k == 0) || (k == 2) || (k == 6);
      s.md_div   = (k == 2);
      s.md_use   = (k >= 6);
      s.x_busy   = ((k >= 1) && (k <= 5)) || ((k >= 7) && (k <= 11));
      s.x_stall  = (k >= 6) && (k <= 11);
      drive(s, $sformatf("mult_restart_k%0d", k));
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (observe() !== e.v) begin
        n_fail++;
        $display("FAIL %s: observed=%h expected=%h", e.tag, observe(), e.v);
      end
      if (s.clr) model_cnt = '0;
      else if (s.x_stall) model_cnt++;
      tick();
    end
  endtask

  task automatic test_async_reset();
    stim_t s;
    sb_t   e;
    for (int k = 0; k <= 3; k++) begin
      s = '0;
      s.md_start = (k == 0);
      s.md_div   = 1'b1;
      s.x_busy   = (k >= 1);
      drive(s, $sformatf("div_pre_reset_k%0d", k));
      if (k < 3) @(negedge clk);
      else #1;
      e = exp_q.pop_front();
      n_tests++;
      if (observe() !== e.v) begin
        n_fail++;
        $display("FAIL %s: observed=%h expected=%h", e.tag, observe(), e.v);
      end
      if (k < 3) tick();
    end
    // Mid-cycle at S+3: pull reset with a data hazard present; no clock edge in between.
    model_cnt = '0;
    s = '0;
    s.id_rs = 5'd2; s.ex_rd = 5'd2; s.ex_tnew = 2'd3; s.md_use = 1'b1;
    s.x_stall = 1'b1;
    drive(s, "reset_async_mid_div");
    reset_n = 1'b0;
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if (observe() !== e.v) begin
      n_fail++;
      $display("FAIL %s: observed=%h expected=%h", e.tag, observe(), e.v);
    end
    tick();
    drive(s, "reset_held_across_edge");
    @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if (observe() !== e.v) begin
      n_fail++;
      $display("FAIL %s: observed=%h expected=%h", e.tag, observe(), e.v);
    end
    s = '0;
    drive(s, "post_release_idle");
    reset_n = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if (observe() !== e.v) begin
      n_fail++;
      $display("FAIL %s: observed=%h expected=%h", e.tag, observe(), e.v);
    end
    tick();
  endtask

  // Narrow counter: 20 stall cycles saturate at 15, then a clear wins over a stall.
  task automatic test_saturation();
    logic [3:0] exp4;
    logic [3:0] sat_q[$];
    logic       clr;
    logic [3:0] want;
    exp4 = 4'd0;
    apply('0);
    for (int k = 0; k <= 22; k++) begin
      clr = (k == 20);
      bus4_set(1'b1, clr);
      sat_q.push_back(exp4);
      @(negedge clk);
      want = sat_q.pop_front();
      n_tests++;
      if (bus4.stall_cnt !== want) begin
        n_fail++;
        $display("FAIL sat_cnt_k%0d: observed=%0d expected=%0d", k, bus4.stall_cnt, want);
      end
      if (clr) exp4 = 4'd0;
      else if (exp4 != 4'hF) exp4 = exp4 + 4'd1;
      tick();
    end
    bus4_set(1'b0, 1'b0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    model_cnt = '0;
    reset_n   = 1'b0;
    apply('0);
    bus4_set(1'b0, 1'b0);

    test_reset();
    test_load_use();
    test_forwarding();
    test_div_busy();
    test_mult_restart();
    test_async_reset();
    test_saturation();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: observed=%0d pending expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
